// File: rtl/pmux_pipe_if.sv
// -----------------------------------------------------------------------------
// pmux_pipe_if
// Bundles the pmux_pipe input and output handshake/data signals.
// Signal suffixes (_i/_o) are named from the point of view of the mux.
//   valid_i/ready_o     : input handshake
//   sel_i/data_i        : per-channel select bits and packed channel words
//   default_i           : word delivered when no select bit is set
//   valid_o/ready_i     : output handshake
//   q_o/grant_o         : selected word and one-hot winning channel
// Modports: slave = the mux, master = the block driving and draining it.
// -----------------------------------------------------------------------------
interface pmux_pipe_if #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 16
);
    logic                    valid_i;
    logic                    ready_o;
    logic [N_CH-1:0]         sel_i;
    logic [N_CH*WIDTH-1:0]   data_i;
    logic [WIDTH-1:0]        default_i;
    logic                    valid_o;
    logic                    ready_i;
    logic [WIDTH-1:0]        q_o;
    logic [N_CH-1:0]         grant_o;

    modport slave (
        input  valid_i, sel_i, data_i, default_i, ready_i,
        output ready_o, valid_o, q_o, grant_o
    );

    modport master (
        output valid_i, sel_i, data_i, default_i, ready_i,
        input  ready_o, valid_o, q_o, grant_o
    );
endinterface

// File: rtl/pmux_pipe.sv
// -----------------------------------------------------------------------------
// pmux_pipe
// Registered priority multiplexer with a valid/ready output stage and a
// one-entry skid buffer. The winning channel's word and its one-hot grant
// are delivered together; with no select bit set, default_i is delivered
// with an all-zero grant.
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : pmux_pipe_if.slave (input handshake, selects, data, output side)
// Optional feature: define PMUX_PIPE_RR_EN to replace fixed lowest-index
// priority with round-robin arbitration (pointer advances on input accept).
// -----------------------------------------------------------------------------
module pmux_pipe #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    pmux_pipe_if.slave   bus
);
    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [N_CH-1:0]  grant;
    } word_t;

    // Lowest set bit of v as a one-hot vector (zero when v is zero).
    function automatic logic [N_CH-1:0] lowest_onehot(input logic [N_CH-1:0] v);
        logic [N_CH-1:0] res;
        res = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (v[k]) begin
                res    = '0;
                res[k] = 1'b1;
            end
        end
        return res;
    endfunction

    logic            in_acc;
    logic            out_acc;
    logic [N_CH-1:0] grant;
    word_t           new_word;

    word_t out_q, out_d;
    word_t skid_q, skid_d;
    logic  out_valid_q, out_valid_d;
    logic  skid_valid_q, skid_valid_d;

    assign in_acc  = bus.valid_i && !skid_valid_q;
    assign out_acc = out_valid_q && bus.ready_i;

`ifdef PMUX_PIPE_RR_EN
    localparam int PTR_W = $clog2(N_CH);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]  above_ptr;
    logic [N_CH-1:0]  masked_sel;
    logic [PTR_W-1:0] win_idx;

    // Search channels at or above the pointer first; if none is set, the
    // wrapped search reduces to the plain lowest set bit of sel_i.
    always_comb begin
        above_ptr = '0;
        for (int k = 0; k < N_CH; k++) begin
            above_ptr[k] = (k >= int'(rr_ptr_q));
        end
        masked_sel = bus.sel_i & above_ptr;
        grant      = (masked_sel != '0) ? lowest_onehot(masked_sel)
                                        : lowest_onehot(bus.sel_i);
        win_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) win_idx = PTR_W'(k);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (in_acc && (bus.sel_i != '0)) begin
            rr_ptr_d = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr_q <= '0;
        else         rr_ptr_q <= rr_ptr_d;
    end
`else
    assign grant = lowest_onehot(bus.sel_i);
`endif

    // grant is one-hot or zero, so an OR-reduction of gated words is exact.
    always_comb begin
        new_word.grant = grant;
        new_word.q     = (grant == '0) ? bus.default_i : '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) new_word.q = new_word.q | bus.data_i[k*WIDTH +: WIDTH];
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || bus.ready_i) begin
            // Output register is free this cycle. A full skid has priority;
            // in_acc is impossible then because ready_o is low.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_acc) begin
                out_d       = new_word;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_acc) begin
            // Output stalled: park the new result in the skid.
            skid_d       = new_word;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the data registers are reset as well as the valid flags, so q_o
    // and grant_o read zero out of reset rather than undefined values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.ready_o = !skid_valid_q;
    assign bus.valid_o = out_valid_q;
    assign bus.q_o     = out_q.q;
    assign bus.grant_o = out_q.grant;
endmodule

// File: doc/pmux_pipe.md
# pmux_pipe

Registered, parametrised priority multiplexer: selects one of `N_CH` data words by a per-channel select vector and delivers the result through a valid/ready output stage with a one-entry skid buffer. It is the pipelined successor to the combinational parallel mux used in datapath lowering, and sits between operand sources and downstream stages that can stall. The output also carries the winning channel's one-hot grant.

## Interface
- `N_CH`, 8, number of data channels (≥2)
- `WIDTH`, 16, data word width (≥1)
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `valid_i`  in  1  input transaction present
- `ready_o`  out  1  block can accept input this cycle
- `sel_i`  in  N_CH  per-channel select bits; more than one may be set
- `data_i`  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `default_i`  in  WIDTH  word delivered when no select bit is set
- `valid_o`  out  1  output transaction present
- `ready_i`  in  1  downstream accepts output
- `q_o`  out  WIDTH  selected word
- `grant_o`  out  N_CH  one-hot winning channel; all zero when `default_i` was taken

## Operation
- Input accept: `valid_i && ready_o`. Output accept: `valid_o && ready_i`.
- Winner selection, fixed priority: the lowest index k with `sel_i[k]=1` wins. `q_o` is `data_i[k]` and `grant_o` is `1<<k`.
- If `sel_i==0`: `q_o=default_i`, `grant_o=0`.
- Storage: an output register (`valid_o`, `q_o`, `grant_o`) plus one skid register of the same content.
- `ready_o = !skid_valid`. It is registered state, with no combinational path from `ready_i`.
- Accept while the output register is empty or being drained: the new result loads the output register.
- Accept while the output register holds data and `ready_i=0`: the new result loads the skid register.
- Output drains while the skid is full: the skid contents move to the output register and the skid empties.
- Output holds stable (`q_o`, `grant_o` unchanged) while `valid_o && !ready_i`.
- Order is preserved; no transaction is dropped or duplicated.

## Timing
- Latency: an input accepted in cycle n appears on `valid_o` in cycle n+1, when the output register is free.
- Throughput: 1 transaction per cycle while `ready_i=1`.
- Reset, asynchronous: `valid_o=0`, `q_o=0`, `grant_o=0`, skid empty, and `ready_o=1` from reset release onward.
- Reset mid-operation discards both stored words. No output accept is signalled for them.
- Simultaneous input accept, output accept and full skid cannot occur, because `ready_o=0` when the skid is full.
- Simultaneous input accept and output accept with the skid empty: the new word replaces the output register and `valid_o` stays 1.
- `ready_o` falls in the cycle after the skid fills. It rises in the cycle after the skid drains.

## Configuration
- Macro: `PMUX_PIPE_RR_EN`.
- Defined: round-robin arbitration replaces fixed priority.
  - A pointer register `rr_ptr`, `$clog2(N_CH)` bits, resets to 0.
  - The winner is the first set bit at or above `rr_ptr`, wrapping modulo `N_CH`.
  - On each input accept with `sel_i!=0`, `rr_ptr` is set to (winner+1) mod `N_CH`.
  - With `sel_i==0`, or with no accept, `rr_ptr` is unchanged.
  - `rr_ptr` updates at input accept time, not at output time.
- Undefined: fixed lowest-index priority. No pointer state exists.

## Test plan
- Reset, then `sel_i=8'b0010_0100`, `data_i` channel k = 0x1000+k, `valid_i=1`, `ready_i=1` -> next cycle `valid_o=1`, `q_o=0x1002`, `grant_o=8'b0000_0100`.
- `sel_i=0`, `default_i=0xBEEF` -> `q_o=0xBEEF`, `grant_o=0`.
- Back-pressure: `ready_i=0` with 3 consecutive inputs A, B, C offered.
  - A is held on the output and B goes to the skid.
  - `ready_o=0` from the cycle after B is accepted; C waits.
  - Raise `ready_i`: outputs appear in order A, B, C with no gaps or duplicates.
- Assert `rst_ni=0` asynchronously mid-stall with the skid full -> immediately `valid_o=0`, `q_o=0`, `grant_o=0`, and `ready_o=1` after release.
- `PMUX_PIPE_RR_EN` defined: `sel_i=8'hFF` on 9 consecutive accepts -> `grant_o` walks bit 0..7, then bit 0. Then `sel_i=8'b1000_0001` with `rr_ptr=1` -> bit 7 wins, and the next accept yields bit 0.
- Random `sel_i`, `data_i` and `ready_i` for 1000 cycles, seed 123 -> the scoreboard model matches every output transaction.
